spike_train_gen: RTL and testbench

Stimulus-side driver for the classification output neurons. On a start request it opens an enable window and emits a programmed number of clean, edge-separated spike pulses on two channels. The pulses are shaped so a receiver that counts registered rising edges of `spike & en` sees exactly the programmed count per channel. It sits between the upstream layer or testbench sequencer and the output-neuron counters, and drives their `en_u`/`spike1`/`spike2` inputs.

---
 rtl/spike_train_if.sv | 31 +++
 rtl/spike_train_gen.sv | 129 ++++++++++++
 tb/tb_spike_train_gen.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/spike_train_if.sv
// ---------------------------------------------------------------------------
// Module      : spike_train_if
// Description : Request / pulse-train bundle between sequencer and generator.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface spike_train_if #(
    parameter int CNT_W = 3
);
    logic             start;
    logic [CNT_W-1:0] count1;
    logic [CNT_W-1:0] count2;
    logic             en_u;
    logic             spike1;
    logic             spike2;
    logic             busy;
    logic             done;

    modport master (
        output start, count1, count2,
        input  en_u, spike1, spike2, busy, done
    );

    modport slave (
        input  start, count1, count2,
        output en_u, spike1, spike2, busy, done
    );
endinterface

`default_nettype wire

// File: rtl/spike_train_gen.sv
// ---------------------------------------------------------------------------
// Module      : spike_train_gen
// Description : Emits programmed, edge-separated spike bursts inside an enable window.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module spike_train_gen #(
    parameter int CNT_W    = 3,
    parameter int LEAD_CYC = 2,
    parameter int HIGH_CYC = 1,
    parameter int LOW_CYC  = 1,
    parameter int TAIL_CYC = 3
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    spike_train_if.slave    bus
);

    localparam logic [7:0]       c_lead = 8'(LEAD_CYC);
    localparam logic [7:0]       c_high = 8'(HIGH_CYC);
    localparam logic [7:0]       c_low  = 8'(LOW_CYC);
    localparam logic [7:0]       c_tail = 8'(TAIL_CYC);
    localparam logic [CNT_W-1:0] c_one  = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LEAD = 3'd1,
        S_HIGH = 3'd2,
        S_LOW  = 3'd3,
        S_TAIL = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t           r_state;
    logic [7:0]       r_phase;
    logic [CNT_W-1:0] r_rem1;
    logic [CNT_W-1:0] r_rem2;
    logic             w_any_rem;
    logic             w_phase_end;

    assign w_any_rem   = (r_rem1 != '0) || (r_rem2 != '0);
    assign w_phase_end = (r_phase == 8'd1);

    // Outputs are assigned alongside the state they belong to, so they are
    // valid in the same cycle the new state becomes current.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_phase    <= 8'd0;
            r_rem1     <= '0;
            r_rem2     <= '0;
            bus.en_u   <= 1'b0;
            bus.spike1 <= 1'b0;
            bus.spike2 <= 1'b0;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_rem1   <= bus.count1;
                        r_rem2   <= bus.count2;
                        r_phase  <= c_lead;
                        r_state  <= S_LEAD;
                        bus.en_u <= 1'b1;
                        bus.busy <= 1'b1;
                    end
                end
                S_LEAD, S_LOW: begin
                    if (w_phase_end) begin
                        if (w_any_rem) begin
                            r_state    <= S_HIGH;
                            r_phase    <= c_high;
                            bus.spike1 <= (r_rem1 != '0);
                            bus.spike2 <= (r_rem2 != '0);
                        end else begin
                            r_state <= S_TAIL;
                            r_phase <= c_tail;
                        end
                    end else begin
                        r_phase <= r_phase - 8'd1;
                    end
                end
                S_HIGH: begin
                    if (w_phase_end) begin
                        // Exhausted channels stay at zero rather than wrapping.
                        if (r_rem1 != '0) r_rem1 <= r_rem1 - c_one;
                        if (r_rem2 != '0) r_rem2 <= r_rem2 - c_one;
                        r_state    <= S_LOW;
                        r_phase    <= c_low;
                        bus.spike1 <= 1'b0;
                        bus.spike2 <= 1'b0;
                    end else begin
                        r_phase <= r_phase - 8'd1;
                    end
                end
                S_TAIL: begin
                    if (w_phase_end) begin
                        r_state  <= S_DONE;
                        r_phase  <= 8'd1;
                        bus.en_u <= 1'b0;
                        bus.done <= 1'b1;
                    end else begin
                        r_phase <= r_phase - 8'd1;
                    end
                end
                S_DONE: begin
                    r_state  <= S_IDLE;
                    r_phase  <= 8'd0;
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_phase    <= 8'd0;
                    bus.en_u   <= 1'b0;
                    bus.spike1 <= 1'b0;
                    bus.spike2 <= 1'b0;
                    bus.busy   <= 1'b0;
                    bus.done   <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_spike_train_gen.sv
// ---------------------------------------------------------------------------
// Module      : tb_spike_train_gen
// Description : Directed, table-driven bench for spike_train_gen.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_spike_train_gen;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [2:0] count1;
    logic [2:0] count2;
    logic       sel;
    int         n_checks;
    int         n_fail;

    spike_train_if #(.CNT_W(3)) if_a ();
    spike_train_if #(.CNT_W(3)) if_b ();

    assign if_a.start  = start;
    assign if_a.count1 = count1;
    assign if_a.count2 = count2;
    assign if_b.start  = start;
    assign if_b.count1 = count1;
    assign if_b.count2 = count2;

    spike_train_gen dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_a.slave)
    );

    spike_train_gen #(
        .CNT_W    (3),
        .LEAD_CYC (2),
        .HIGH_CYC (2),
        .LOW_CYC  (3),
        .TAIL_CYC (3)
    ) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_b.slave)
    );

    logic o_en, o_s1, o_s2, o_busy, o_done;
    assign o_en   = sel ? if_b.en_u   : if_a.en_u;
    assign o_s1   = sel ? if_b.spike1 : if_a.spike1;
    assign o_s2   = sel ? if_b.spike2 : if_a.spike2;
    assign o_busy = sel ? if_b.busy   : if_a.busy;
    assign o_done = sel ? if_b.done   : if_a.done;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  c1;
        logic [2:0]  c2;
        int          len;
        logic [63:0] m1;
        logic [63:0] m2;
        logic [63:0] men;
        int          r1;
        int          r2;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge; start is sampled by the following posedge. Returns
    // at the first negedge with busy low, so chained calls are back-to-back.
    task automatic run_burst(input logic [2:0] c1, input logic [2:0] c2, input int inject,
                             output int len, output logic [63:0] m1, output logic [63:0] m2,
                             output logic [63:0] men, output logic [63:0] mdone,
                             output int r1, output int r2);
        logic p1, p2, cur1, cur2;
        int cyc;
        count1 = c1; count2 = c2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        m1 = '0; m2 = '0; men = '0; mdone = '0;
        r1 = 0; r2 = 0; p1 = 1'b0; p2 = 1'b0; cyc = 0;
        while (o_busy && cyc < 100) begin
            if (inject > 0 && cyc == inject) begin start = 1'b1; count1 = 3'd5; end
            if (inject > 0 && cyc == inject + 1) start = 1'b0;
            if (o_s1)   m1    |= 64'd1 << cyc;
            if (o_s2)   m2    |= 64'd1 << cyc;
            if (o_en)   men   |= 64'd1 << cyc;
            if (o_done) mdone |= 64'd1 << cyc;
            cur1 = o_en & o_s1;
            cur2 = o_en & o_s2;
            if (cur1 && !p1) r1++;
            if (cur2 && !p2) r2++;
            p1 = cur1; p2 = cur2;
            cyc++;
            @(negedge clk);
        end
        start = 1'b0;
        if (cyc >= 100) begin
            n_checks++; n_fail++;
            $display("FAIL burst_timeout: busy still high after %0d cycles, required to drop", cyc);
        end
        len = cyc;
    endtask

    task automatic chk_burst(input string tag, input vec_t v);
        int len, r1, r2;
        logic [63:0] m1, m2, men, mdone;
        run_burst(v.c1, v.c2, 0, len, m1, m2, men, mdone, r1, r2);
        chk({tag, "_len"},   64'(len), 64'(v.len));
        chk({tag, "_s1"},    m1, v.m1);
        chk({tag, "_s2"},    m2, v.m2);
        chk({tag, "_en"},    men, v.men);
        chk({tag, "_done"},  mdone, 64'd1 << (v.len - 1));
        chk({tag, "_rcv1"},  64'(r1), 64'(v.r1));
        chk({tag, "_rcv2"},  64'(r2), 64'(v.r2));
    endtask

    initial begin
        int          len, r1, r2;
        logic [63:0] m1, m2, men, mdone;
        logic        bad, saw_done;
        vec_t        v77;

        n_checks = 0; n_fail = 0;
        // Busy cycles are 1-based in the plan; bit (c-1) of a mask is cycle c.
        vecs[0] = '{3'd3, 3'd1, 12, 64'h54,   64'h04, 64'h7FF,   3, 1};
        vecs[1] = '{3'd0, 3'd0,  6, 64'h0,    64'h0,  64'h1F,    0, 0};
        vecs[2] = '{3'd7, 3'd0, 20, 64'h5554, 64'h0,  64'h7FFFF, 7, 0};
        vecs[3] = '{3'd1, 3'd2, 10, 64'h04,   64'h14, 64'h1FF,   1, 2};
        vecs[4] = '{3'd2, 3'd2, 10, 64'h14,   64'h14, 64'h1FF,   2, 2};
        v77     = '{3'd7, 3'd7, 41, 64'h3_18C6_318C, 64'h3_18C6_318C, 64'hFF_FFFF_FFFF, 7, 7};

        rst_n = 1'b0; start = 1'b0; count1 = '0; count2 = '0; sel = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_state", {54'd0, if_a.en_u, if_a.spike1, if_a.spike2, if_a.busy, if_a.done,
                            if_b.en_u, if_b.spike1, if_b.spike2, if_b.busy, if_b.done}, 64'd0);
        rst_n = 1'b1;
        bad = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (if_a.en_u | if_a.spike1 | if_a.spike2 | if_a.busy | if_a.done |
                if_b.en_u | if_b.spike1 | if_b.spike2 | if_b.busy | if_b.done) bad = 1'b1;
        end
        chk("idle_quiet", 64'(bad), 64'd0);

        // Wide-pulse variant: 7 pulses, 2 high / 3 low, no receiver wrap.
        sel = 1'b1;
        chk_burst("w77", v77);
        sel = 1'b0;

        foreach (vecs[i]) chk_burst($sformatf("v%0d", i), vecs[i]);

        // Mid-burst start with a new count must be ignored.
        run_burst(3'd3, 3'd1, 4, len, m1, m2, men, mdone, r1, r2);
        chk("ign_len",  64'(len), 64'd12);
        chk("ign_s1",   m1, 64'h54);
        chk("ign_s2",   m2, 64'h04);
        chk("ign_rcv1", 64'(r1), 64'd3);

        // Back-to-back: start in the first idle cycle after done.
        chk_burst("b2b", vecs[1]);

        // Reset during the second pulse's HIGH aborts with no done.
        count1 = 3'd3; count2 = 3'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        saw_done = o_done;
        repeat (4) begin
            @(negedge clk);
            saw_done |= o_done;
        end
        chk("abort_pre_s1", 64'(o_s1), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_outs", {59'd0, if_a.en_u, if_a.spike1, if_a.spike2, if_a.busy, if_a.done}, 64'd0);
        rst_n = 1'b1;
        chk("abort_no_done", 64'(saw_done), 64'd0);
        chk_burst("post", vecs[4]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
